fir_out_stage: RTL
==================

Name: fir_out_stage

Overview:
- Downstream consumer of the 3-tap FIR core.
- Captures each new 18-bit filter result when READY_RESULT rises, then rounds and saturates it to an 8-bit sample.
- Buffers samples in a small first-word-fall-through FIFO and presents them on a valid/ready interface to the next stage (DAC/serializer).
- Tracks saturation and overflow events for debug.

Parameters:
- IN_W, 18, width of the FIR result Y_ALL
- OUT_W, 8, width of the output sample
- SHIFT, 3, right shift applied after rounding (1..IN_W-1)
- DEPTH, 4, FIFO entries (power of 2, ≥2)

Ports:
- CLK  in  1  system clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- Y_ALL  in  IN_W  FIR result, unsigned
- READY_RESULT  in  1  level from FIR; result valid while high
- OUT_DATA  out  OUT_W  FIFO head sample
- OUT_VALID  out  1  FIFO not empty
- OUT_READY  in  1  consumer accepts OUT_DATA when OUT_VALID & OUT_READY
- SAT_HIT  out  1  sticky: at least one sample saturated
- OVF  out  1  sticky: at least one sample dropped on full FIFO
- DROP_CNT  out  8  dropped-sample count, saturates at 255
- CLR_FLAGS  in  1  synchronous clear of SAT_HIT, OVF, DROP_CNT

Behaviour:
- Reset (RST_N=0, asynchronous): all of the following clear immediately, independent of CLK:
  - outputs: OUT_DATA=0, OUT_VALID=0, SAT_HIT=0, OVF=0, DROP_CNT=0
  - internal state: FIFO pointers/count, capture stage, and READY_RESULT history register.
- Reset mid-operation discards all buffered samples. After reset release, a READY_RESULT that is already high is not treated as a rising edge (history resets to 1).
- Edge detect: a capture occurs at posedge k when READY_RESULT=1 at k and READY_RESULT=0 at k-1. A level held high for many cycles yields exactly one capture.
- Stage 1 (posedge k): CAP <= Y_ALL; CAP_V <= 1.
- Stage 2 (posedge k+1), when CAP_V=1:
  - R = (CAP + 2^(SHIFT-1)) >> SHIFT, computed at IN_W+1 bits so no wrap.
  - If R > 2^OUT_W-1, the sample is 2^OUT_W-1 and SAT_HIT <= 1; otherwise the sample is R[OUT_W-1:0].
  - The sample is pushed to the FIFO.
- Latency: a sample reaches an empty FIFO at posedge k+1; OUT_VALID is high in the cycle after that posedge (2 clocks after capture).
- FIFO: first-word fall-through. OUT_DATA is the head entry. OUT_VALID = (count != 0). Pop on OUT_VALID & OUT_READY at posedge.
- Boundary conditions:
  - Push when full and no pop in the same cycle: the sample is dropped, OVF <= 1, DROP_CNT += 1 (stops at 255). FIFO contents are unchanged.
  - Push and pop in the same cycle while full: both happen; the count stays DEPTH and no drop is recorded.
  - Push and pop in the same cycle while empty: no pop occurs because OUT_VALID=0. The pushed sample appears the next cycle.
  - OUT_READY while OUT_VALID=0: ignored.
  - Read and write pointers wrap modulo DEPTH. Count runs 0..DEPTH and uses a separate counter of clog2(DEPTH)+1 bits.
- OUT_DATA holds its value while OUT_VALID=1 and OUT_READY=0. When empty, OUT_DATA keeps the last popped value (don't-care to the consumer).
- CLR_FLAGS at posedge clears SAT_HIT, OVF and DROP_CNT. If a saturation or drop event occurs in the same cycle, the event wins: the flag is set and DROP_CNT becomes 1.

Decomposition:
- Shared package (fir_pkg) holds:
  - FIR widths (IN_W=18, sample width 8)
  - default SHIFT=3
  - a function for round-and-saturate, reusable by the golden model.
- One sub-module: fir_out_fifo (parameterised DEPTH/OUT_W synchronous FWFT FIFO with full/empty/count). Edge detect, rounding and flags stay in the top.

Test Plan:
- Rounding: Y_ALL=12 then 11, with one READY_RESULT pulse each, OUT_READY=1 → OUT_DATA 2 then 1. Each OUT_VALID appears 2 clocks after capture; SAT_HIT stays 0.
- Saturation: Y_ALL=1530 → 191 with SAT_HIT=0; then Y_ALL=2100 → 255 with SAT_HIT=1; CLR_FLAGS pulse → SAT_HIT=0.
- Level hold: READY_RESULT high for 10 cycles with Y_ALL changing each cycle → exactly one sample, equal to the value at the first high cycle.
- Backpressure/overflow: OUT_READY=0, 6 results 8,16,24,32,40,48 → FIFO holds 1,2,3,4; OVF=1, DROP_CNT=2. Then OUT_READY=1 → 1,2,3,4 pop in order, then OUT_VALID=0.
- Full with simultaneous push/pop: FIFO full, push timed with a pop → no drop, DROP_CNT unchanged, new sample appears last.
- Async reset: assert RST_N=0 between clock edges with 3 samples buffered → OUT_VALID, flags and DROP_CNT go to 0 immediately. After release with READY_RESULT held high → no capture until it falls and rises again.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared FIR widths plus a round-and-saturate helper for reference models.
package fir_pkg;

  localparam int unsigned FIR_IN_W  = 18;
  localparam int unsigned FIR_OUT_W = 8;
  localparam int unsigned FIR_SHIFT = 3;

  typedef struct packed {
    logic                 sat;
    logic [FIR_OUT_W-1:0] sample;
  } rs_t;

  // Round half-up, shift right, clamp to the sample range; shift must be 1..FIR_IN_W-1.
  function automatic rs_t round_sat(input logic [FIR_IN_W-1:0] y, input int unsigned shift);
    logic [FIR_IN_W:0] sum;
    logic [FIR_IN_W:0] r;
    rs_t               res;
    sum        = {1'b0, y} + ((FIR_IN_W + 1)'(1) << (shift - 1));
    r          = sum >> shift;
    res.sat    = |r[FIR_IN_W:FIR_OUT_W];
    res.sample = res.sat ? '1 : r[FIR_OUT_W-1:0];
    return res;
  endfunction

endpackage

// File: rtl/fir_out_fifo.sv
// First-word-fall-through FIFO; the head sample and its valid flag are registered.
module fir_out_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full_c,
  output logic [W-1:0] head,
  output logic         head_valid
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_next_c;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next_c;
  logic          do_push_c;
  logic          do_pop_c;
  logic [W-1:0]  head_next_c;

  // Next head comes from the incoming sample when it lands at the new read slot.
  always_comb begin
    do_pop_c     = pop & (count != '0);
    full_c       = (count == CW'(DEPTH));
    do_push_c    = push & (~full_c | do_pop_c);
    rd_next_c    = rd_ptr + AW'(do_pop_c);
    count_next_c = count + CW'(do_push_c) - CW'(do_pop_c);
    head_next_c  = head;
    if (count_next_c != '0) begin
      head_next_c = (do_push_c && (wr_ptr == rd_next_c)) ? din : mem[rd_next_c];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head       <= '0;
      head_valid <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr + AW'(do_push_c);
      rd_ptr     <= rd_next_c;
      count      <= count_next_c;
      head       <= head_next_c;
      head_valid <= (count_next_c != '0);
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push_c) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/fir_out_stage.sv
// FIR result consumer: edge-triggered capture, round/saturate to a sample,
// FWFT buffering toward the next stage, and sticky debug flags.
module fir_out_stage
  import fir_pkg::*;
#(
  parameter int unsigned IN_W  = FIR_IN_W,
  parameter int unsigned OUT_W = FIR_OUT_W,
  parameter int unsigned SHIFT = FIR_SHIFT,
  parameter int unsigned DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [IN_W-1:0]  Y_ALL,
  input  logic             READY_RESULT,
  output logic [OUT_W-1:0] OUT_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             SAT_HIT,
  output logic             OVF,
  output logic [7:0]       DROP_CNT,
  input  logic             CLR_FLAGS
);

  localparam int unsigned SUM_W = IN_W + 1;

  logic             rdy_q;
  logic             rise_c;
  logic             cap_v;
  logic [IN_W-1:0]  cap;
  logic [SUM_W-1:0] sum_c;
  logic [SUM_W-1:0] r_c;
  logic             sat_c;
  logic [OUT_W-1:0] sample_c;
  logic             pop_c;
  logic             full_c;
  logic             drop_c;
  logic             sat_ev_c;

  // History resets high so a level already asserted at reset release is not an edge.
  assign rise_c = READY_RESULT & ~rdy_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rdy_q <= 1'b1;
      cap_v <= 1'b0;
      cap   <= '0;
    end else begin
      rdy_q <= READY_RESULT;
      cap_v <= rise_c;
      if (rise_c) begin
        cap <= Y_ALL;
      end
    end
  end

  always_comb begin
    sum_c    = SUM_W'(cap) + (SUM_W'(1) << (SHIFT - 1));
    r_c      = sum_c >> SHIFT;
    sat_c    = |r_c[SUM_W-1:OUT_W];
    sample_c = sat_c ? '1 : r_c[OUT_W-1:0];
  end

  assign pop_c    = OUT_VALID & OUT_READY;
  assign sat_ev_c = cap_v & sat_c;
  assign drop_c   = cap_v & full_c & ~pop_c;

  fir_out_fifo #(
    .DEPTH (DEPTH),
    .W     (OUT_W)
  ) u_fifo (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .push       (cap_v),
    .din        (sample_c),
    .pop        (pop_c),
    .full_c     (full_c),
    .head       (OUT_DATA),
    .head_valid (OUT_VALID)
  );

  // A same-cycle event beats CLR_FLAGS.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      SAT_HIT  <= 1'b0;
      OVF      <= 1'b0;
      DROP_CNT <= '0;
    end else begin
      SAT_HIT <= sat_ev_c | (SAT_HIT & ~CLR_FLAGS);
      OVF     <= drop_c | (OVF & ~CLR_FLAGS);
      if (drop_c) begin
        DROP_CNT <= CLR_FLAGS ? 8'd1 : ((DROP_CNT == 8'hFF) ? DROP_CNT : DROP_CNT + 8'd1);
      end else if (CLR_FLAGS) begin
        DROP_CNT <= '0;
      end
    end
  end

endmodule
